cnt_step_monitor: RTL and testbench

//   Downstream consumer of the divided-clock 2-bit count (po_cnt of the /4 divider). Re-times the count into
//   the fast clk domain, checks every change is a +1 modulo-2^CNT_W step, and produces one-cycle step/wrap

---
 rtl/cnt_step_monitor_pkg.sv | 13 +
 rtl/cnt_step_monitor_sync_bus.sv | 29 ++
 rtl/cnt_step_monitor.sv | 136 +++++++++++++
 tb/tb_cnt_step_monitor.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_step_monitor_pkg.sv
// Shared definitions for the divided-clock count step monitor:
// FSM state encodings and the state width.
package cnt_step_monitor_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

endpackage

// File: rtl/cnt_step_monitor_sync_bus.sv
// Re-timing flop chain for a multi-bit slow-domain bus; the bus is only
// ever sampled while stable, so plain per-bit staging is sufficient.
module sync_bus #(
    parameter int W      = 2,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] pipe_q [STAGES];

    // Shift the bus through STAGES flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '{default: '0};
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[STAGES-1];

endmodule

// File: rtl/cnt_step_monitor.sv
// Monitors a slow-domain modulo counter in the fast clk domain: validates
// +1 steps, emits step/wrap pulses, keeps a saturating step total and a sticky error.
module cnt_step_monitor
    import cnt_step_monitor_pkg::*;
#(
    parameter int CNT_W       = 2,
    parameter int EVT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] pi_cnt,
    output logic             step_pulse,
    output logic             wrap_pulse,
    output logic             err_flag,
    output logic [EVT_W-1:0] step_total,
    output logic [ST_W-1:0]  state
);

    localparam int                FILL_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [EVT_W-1:0]  EVT_MAX   = '1;

    logic [CNT_W-1:0]  sync_s;
    logic [CNT_W-1:0]  inc_s;
    logic              is_same_s;
    logic              is_step_s;

    state_e            state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  prev_q, prev_d;
    logic              step_q, step_d;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;
    logic [EVT_W-1:0]  total_q, total_d;

    sync_bus #(
        .W      (CNT_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (pi_cnt),
        .q_o   (sync_s)
    );

    assign inc_s     = prev_q + CNT_W'(1);
    assign is_same_s = (sync_s == prev_q);
    assign is_step_s = (sync_s == inc_s);

    // Next-state: fill counter, accepted value, FSM, pulses and step total
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        prev_d  = prev_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        err_d   = err_q;
        total_d = total_q;

        // clr wins over any step or error evaluated in the same cycle
        if (clr) begin
            state_d = ST_INIT;
            fill_d  = '0;
            err_d   = 1'b0;
            total_d = '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (fill_q == FILL_LAST) begin
                        prev_d  = sync_s;
                        fill_d  = '0;
                        state_d = ST_TRACK;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                ST_TRACK: begin
                    if (is_step_s) begin
                        step_d = 1'b1;
                        wrap_d = (prev_q == CNT_MAX);
                        prev_d = sync_s;
                        if (total_q != EVT_MAX) begin
                            total_d = total_q + EVT_W'(1);
                        end else begin
                            total_d = total_q;
                        end
                    end else if (!is_same_s) begin
                        err_d   = 1'b1;
                        prev_d  = sync_s;
                        state_d = ST_ERR;
                    end else begin
                        prev_d = prev_q;
                    end
                end
                ST_ERR: begin
                    prev_d = sync_s;
                end
                default: begin
                    state_d = ST_INIT;
                    fill_d  = '0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            fill_q  <= '0;
            prev_q  <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            prev_q  <= prev_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            total_q <= total_d;
        end
    end

    assign step_pulse = step_q;
    assign wrap_pulse = wrap_q;
    assign err_flag   = err_q;
    assign step_total = total_q;
    assign state      = state_q;

endmodule

// File: tb/tb_cnt_step_monitor.sv
// Randomized self-checking bench for cnt_step_monitor: an event-level model
// schedules the expected outcome of each input change and every cycle is compared.
module tb_cnt_step_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] pi_cnt = 2'd0;

    logic       stp_a, wrp_a, err_a;
    logic [7:0] tot_a;
    logic [1:0] st_a;
    logic       stp_b, wrp_b, err_b;
    logic [3:0] tot_b;
    logic [1:0] st_b;
    logic [21:0] obs;

    int checks = 0;
    int failures = 0;

    typedef struct { int due; int val; } chg_t;
    chg_t pend[$];
    int   edge_n = 0;
    int   m_prev, m_init_left, m_state, m_tot, m_tot4;
    bit   m_step, m_wrap, m_err;

    always #5 clk = ~clk;

    cnt_step_monitor #(.CNT_W(2), .EVT_W(8), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .pi_cnt(pi_cnt),
        .step_pulse(stp_a), .wrap_pulse(wrp_a), .err_flag(err_a),
        .step_total(tot_a), .state(st_a)
    );

    cnt_step_monitor #(.CNT_W(2), .EVT_W(4), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .pi_cnt(pi_cnt),
        .step_pulse(stp_b), .wrap_pulse(wrp_b), .err_flag(err_b),
        .step_total(tot_b), .state(st_b)
    );

    assign obs = {st_a, err_a, stp_a, wrp_a, tot_a, st_b, err_b, stp_b, wrp_b, tot_b};

    function automatic logic [21:0] expv();
        return {2'(m_state), m_err, m_step, m_wrap, 8'(m_tot),
                2'(m_state), m_err, m_step, m_wrap, 4'(m_tot4)};
    endfunction

    function automatic void model_reset();
        pend.delete();
        m_state = 0; m_init_left = 3;
        m_tot = 0; m_tot4 = 0;
        m_step = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
    endfunction

    // A change is seen by the monitor two edges after it is sampled; its outcome shows one edge later.
    function automatic void model_edge();
        int v;
        m_step = 1'b0; m_wrap = 1'b0;
        if (!rst || clr) begin
            model_reset();
        end else if (m_state == 0) begin
            while (pend.size() > 0 && pend[0].due <= edge_n) void'(pend.pop_front());
            m_init_left--;
            if (m_init_left == 0) begin
                m_state = 1;
                m_prev = int'(pi_cnt);
            end
        end else if (pend.size() > 0 && pend[0].due == edge_n) begin
            v = pend.pop_front().val;
            if (m_state == 1) begin
                if (v == (m_prev + 1) % 4) begin
                    m_step = 1'b1;
                    m_wrap = (v == 0);
                    if (m_tot < 255) m_tot++;
                    if (m_tot4 < 15) m_tot4++;
                end else begin
                    m_err = 1'b1;
                    m_state = 2;
                end
            end
            m_prev = v;
        end
    endfunction

    task automatic tick(input bit c);
        clr = c;
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        clr = 1'b0;
    endtask

    task automatic set_pi(input int v);
        logic [1:0] nv;
        nv = 2'(v);
        if (nv != pi_cnt) begin
            pi_cnt = nv;
            pend.push_back(chg_t'{due: edge_n + 3, val: int'(nv)});
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; pi_cnt = 2'd0; model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 22'd0) begin
            failures++; $display("FAIL reset_hold got=%h exp=%h", obs, 22'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0);
            checks++;
            if (obs !== expv()) begin
                failures++; $display("FAIL reset_init edge=%0d got=%h exp=%h", edge_n, obs, expv());
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (st_a !== ((i == 2) ? 2'd1 : 2'd0)) begin
                    failures++; $display("FAIL reset_state i=%0d got=%0d", i, st_a);
                end
            end
        end
    endtask

    task automatic test_count();
        int nstep = 0;
        int nwrap = 0;
        int seq[4] = '{1, 2, 3, 0};
        for (int k = 0; k < 4; k++) begin
            set_pi(seq[k]);
            for (int i = 0; i < 4; i++) begin
                tick(1'b0);
                nstep += int'(stp_a); nwrap += int'(wrp_a);
                checks++;
                if (obs !== expv()) begin
                    failures++; $display("FAIL count edge=%0d got=%h exp=%h", edge_n, obs, expv());
                end
            end
        end
        checks++;
        if (nstep != 4 || nwrap != 1 || tot_a !== 8'd4) begin
            failures++; $display("FAIL count_tot steps=%0d wraps=%0d total=%0d exp 4/1/4", nstep, nwrap, tot_a);
        end
    endtask

    task automatic test_error();
        int vals[3] = '{1, 3, 0};
        for (int k = 0; k < 3; k++) begin
            set_pi(vals[k]);
            for (int i = 0; i < 5; i++) begin
                tick(1'b0);
                checks++;
                if (obs !== expv()) begin
                    failures++; $display("FAIL error edge=%0d got=%h exp=%h", edge_n, obs, expv());
                end
            end
        end
        checks++;
        if (err_a !== 1'b1 || st_a !== 2'd2 || tot_a !== 8'd5) begin
            failures++; $display("FAIL error_sticky err=%0b st=%0d tot=%0d exp 1/2/5", err_a, st_a, tot_a);
        end
    endtask

    task automatic test_clr();
        tick(1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) set_pi(1);
            if (i > 0) tick(1'b0);
            checks++;
            if (obs !== expv()) begin
                failures++; $display("FAIL clr edge=%0d got=%h exp=%h", edge_n, obs, expv());
            end
        end
        checks++;
        if (err_a !== 1'b0 || tot_a !== 8'd1 || st_a !== 2'd1) begin
            failures++; $display("FAIL clr_after err=%0b tot=%0d st=%0d exp 0/1/1", err_a, tot_a, st_a);
        end
    endtask

    task automatic test_random();
        int r, v, gap;
        for (int s = 0; s < 330; s++) begin
            r = int'($urandom_range(0, 99));
            v = int'(pi_cnt);
            if (s < 270 || r < 70) v = (v + 1) % 4;
            else if (r >= 85) v = (v + 2 + int'($urandom_range(0, 1))) % 4;
            set_pi(v);
            gap = 4 + int'($urandom_range(0, 3));
            for (int i = 0; i < gap; i++) begin
                tick(1'b0);
                checks++;
                if (obs !== expv()) begin
                    failures++; $display("FAIL random edge=%0d got=%h exp=%h", edge_n, obs, expv());
                end
            end
            if (s == 269) begin
                checks++;
                if (tot_a !== 8'hFF || tot_b !== 4'hF) begin
                    failures++; $display("FAIL saturate got=%0d/%0d exp 255/15", tot_a, tot_b);
                end
            end
            if (m_state == 2 && $urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 5; i++) begin
                    tick(i == 0);
                    checks++;
                    if (obs !== expv()) begin
                        failures++; $display("FAIL random_clr edge=%0d got=%h exp=%h", edge_n, obs, expv());
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        set_pi(int'(pi_cnt) + 1);
        tick(1'b0);
        tick(1'b0);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 22'd0) begin
            failures++; $display("FAIL async_reset got=%h exp=%h", obs, 22'd0);
        end
        tick(1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) set_pi(int'(pi_cnt) + 1);
            tick(1'b0);
            checks++;
            if (obs !== expv()) begin
                failures++; $display("FAIL async_recover edge=%0d got=%h exp=%h", edge_n, obs, expv());
            end
        end
    endtask

    task automatic test_clr_coincident();
        set_pi(int'(pi_cnt) + 1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        checks++;
        if (tot_a !== 8'd0 || stp_a !== 1'b0 || st_a !== 2'd0 || obs !== expv()) begin
            failures++; $display("FAIL clr_coincident tot=%0d step=%0b st=%0d exp 0/0/0", tot_a, stp_a, st_a);
        end
        for (int i = 0; i < 12; i++) begin
            if (i == 5) set_pi(int'(pi_cnt) + 1);
            tick(1'b0);
            checks++;
            if (obs !== expv()) begin
                failures++; $display("FAIL clr_coincident_after edge=%0d got=%h exp=%h", edge_n, obs, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_error();
        test_clr();
        test_random();
        test_async_reset();
        test_clr_coincident();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
